// File: rtl/btn_pkg.sv
// Shared types and default timing constants for the push-button conditioner.
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        DB_PRESS   = 2'd1,
        HELD       = 2'd2,
        DB_RELEASE = 2'd3
    } btn_state_e;

    localparam int unsigned DEBOUNCE_CYCLES_DEF = 32'd8;
    localparam int unsigned REPEAT_DELAY_DEF    = 32'd64;
    localparam int unsigned REPEAT_PERIOD_DEF   = 32'd16;

endpackage

// File: rtl/btn_sync.sv
// Two-flop synchroniser bringing the raw asynchronous button level into the clk domain.
module btn_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic ff1_r;
    logic ff2_r;

    // Two-stage metastability filter, cleared by the synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            ff1_r <= 1'b0;
            ff2_r <= 1'b0;
        end else begin
            ff1_r <= d;
            ff2_r <= ff1_r;
        end
    end

    assign q = ff2_r;

endmodule

// File: rtl/btn_conditioner.sv
// Turns a bouncy push-button into a debounced level, a press pulse, auto-repeat
// pulses while held, and a wrapping count of accepted presses.
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned REPEAT_DELAY    = REPEAT_DELAY_DEF,
    parameter int unsigned REPEAT_PERIOD   = REPEAT_PERIOD_DEF,
    parameter int unsigned CNT_W           = 32'd16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn,
    output logic       press,
    output logic       hold,
    output logic       repeat_p,
    output logic [7:0] press_count
);

    localparam logic [CNT_W-1:0] DB_LAST     = CNT_W'(DEBOUNCE_CYCLES - 32'd1);
    localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 32'd1);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 32'd1);
    localparam logic             REPEAT_EN   = (REPEAT_DELAY != 32'd0);

    logic             s_s;
    btn_state_e       state_r, state_s;
    logic [CNT_W-1:0] dcnt_r, dcnt_s;
    logic [CNT_W-1:0] rcnt_r, rcnt_s;
    logic [CNT_W-1:0] rep_last_s;
    logic             first_rep_r, first_rep_s;
    logic             press_r, press_s;
    logic             hold_r, hold_s;
    logic             repeat_r, repeat_s;
    logic [7:0]       press_count_r, press_count_s;

    btn_sync u_sync (
        .clk (clk),
        .rst (rst),
        .d   (btn),
        .q   (s_s)
    );

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= IDLE;
            dcnt_r        <= '0;
            rcnt_r        <= '0;
            first_rep_r   <= 1'b0;
            press_r       <= 1'b0;
            hold_r        <= 1'b0;
            repeat_r      <= 1'b0;
            press_count_r <= 8'd0;
        end else begin
            state_r       <= state_s;
            dcnt_r        <= dcnt_s;
            rcnt_r        <= rcnt_s;
            first_rep_r   <= first_rep_s;
            press_r       <= press_s;
            hold_r        <= hold_s;
            repeat_r      <= repeat_s;
            press_count_r <= press_count_s;
        end
    end

    // Next-state logic; pulses default low so they can only last one cycle.
    always_comb begin
        state_s       = state_r;
        dcnt_s        = dcnt_r;
        rcnt_s        = rcnt_r;
        first_rep_s   = first_rep_r;
        press_s       = 1'b0;
        hold_s        = hold_r;
        repeat_s      = 1'b0;
        press_count_s = press_count_r;
        rep_last_s    = first_rep_r ? DELAY_LAST : PERIOD_LAST;

        case (state_r)
            IDLE: begin
                if (s_s) begin
                    state_s = DB_PRESS;
                    dcnt_s  = '0;
                end else begin
                    state_s = IDLE;
                end
            end
            DB_PRESS: begin
                if (!s_s) begin
                    state_s = IDLE;
                end else if (dcnt_r == DB_LAST) begin
                    state_s       = HELD;
                    press_s       = 1'b1;
                    hold_s        = 1'b1;
                    press_count_s = press_count_r + 8'd1;
                    rcnt_s        = '0;
                    first_rep_s   = 1'b1;
                end else begin
                    dcnt_s = dcnt_r + CNT_W'(1);
                end
            end
            HELD: begin
                if (!s_s) begin
                    state_s = DB_RELEASE;
                    dcnt_s  = '0;
                end else if (REPEAT_EN) begin
                    if (rcnt_r == rep_last_s) begin
                        repeat_s    = 1'b1;
                        rcnt_s      = '0;
                        first_rep_s = 1'b0;
                    end else begin
                        rcnt_s = rcnt_r + CNT_W'(1);
                    end
                end else begin
                    rcnt_s = rcnt_r;
                end
            end
            DB_RELEASE: begin
                // rcnt/first_rep untouched here so a rejected release resumes the cadence
                if (s_s) begin
                    state_s = HELD;
                end else if (dcnt_r == DB_LAST) begin
                    state_s = IDLE;
                    hold_s  = 1'b0;
                end else begin
                    dcnt_s = dcnt_r + CNT_W'(1);
                end
            end
            default: begin
                state_s = IDLE;
                hold_s  = 1'b0;
            end
        endcase
    end

    assign press       = press_r;
    assign hold        = hold_r;
    assign repeat_p    = repeat_r;
    assign press_count = press_count_r;

endmodule

// File: tb/tb_btn_conditioner.sv
// Randomised and directed checks of btn_conditioner against a run-length reference model.
module tb_btn_conditioner;

    localparam int DB  = 8;
    localparam int DLY = 64;
    localparam int PER = 16;

    logic       clk;
    logic       rst;
    logic       btn;
    logic       press;
    logic       hold;
    logic       repeat_p;
    logic [7:0] press_count;

    btn_conditioner dut (
        .clk         (clk),
        .rst         (rst),
        .btn         (btn),
        .press       (press),
        .hold        (hold),
        .repeat_p    (repeat_p),
        .press_count (press_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    // Reference model: button delayed two samples, level flips after DB+1
    // consecutive opposing samples, repeat fires on held-sample age milestones.
    bit [1:0] m_pipe;
    bit       m_hold, m_press, m_rep;
    int       m_opp, m_age, m_cnt, m_nrep;

    // Measurements taken from the DUT, compared against model/derived values.
    int cyc = 0;
    int last_press_cyc, first_rep_cyc, hold_fall_cyc;
    int n_press_seen, n_rep_seen, n_fall_seen;
    bit hold_prev;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_edge(input bit r, input bit b);
        bit s;
        m_press = 1'b0;
        m_rep   = 1'b0;
        if (r) begin
            m_pipe = 2'b00;
            m_hold = 1'b0;
            m_opp  = 0;
            m_age  = 0;
            m_cnt  = 0;
        end else begin
            s      = m_pipe[1];
            m_pipe = {m_pipe[0], b};
            if (s == m_hold) begin
                if (m_hold && m_opp == 0) begin
                    m_age++;
                    if (m_age == DLY || (m_age > DLY && (m_age - DLY) % PER == 0)) begin
                        m_rep = 1'b1;
                        m_nrep++;
                    end
                end
                m_opp = 0;
            end else begin
                m_opp++;
                if (m_opp == DB + 1) begin
                    m_opp = 0;
                    if (!m_hold) begin
                        m_hold  = 1'b1;
                        m_press = 1'b1;
                        m_cnt   = (m_cnt + 1) % 256;
                        m_age   = 0;
                    end else begin
                        m_hold = 1'b0;
                    end
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge(rst, btn);
        #1;
        cyc++;
        check("press", 32'(press), 32'(m_press));
        check("hold", 32'(hold), 32'(m_hold));
        check("repeat_p", 32'(repeat_p), 32'(m_rep));
        check("press_count", 32'(press_count), 32'(m_cnt));
        if (press) begin
            n_press_seen++;
            last_press_cyc = cyc;
            first_rep_cyc  = -1;
        end
        if (repeat_p) begin
            n_rep_seen++;
            if (first_rep_cyc < 0) first_rep_cyc = cyc;
        end
        if (hold_prev && !hold) begin
            n_fall_seen++;
            hold_fall_cyc = cyc;
        end
        hold_prev = hold;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        ticks(n);
        rst = 1'b0;
    endtask

    task automatic clear_meas();
        n_press_seen   = 0;
        n_rep_seen     = 0;
        n_fall_seen    = 0;
        last_press_cyc = -1;
        first_rep_cyc  = -1;
        hold_fall_cyc  = -1;
        m_nrep         = 0;
    endtask

    int c0;
    int run_len;

    initial begin
        rst = 1'b1;
        btn = 1'b0;
        m_pipe = 2'b00;
        m_hold = 1'b0;
        m_opp = 0; m_age = 0; m_cnt = 0; m_nrep = 0;
        hold_prev = 1'b0;
        clear_meas();

        // Reset state and basic press/release latency.
        ticks(3);
        rst = 1'b0;
        clear_meas();
        btn = 1'b1;
        c0  = cyc;
        ticks(20);
        check("press_latency", 32'(last_press_cyc - c0), 32'd11);
        check("press_once", 32'(n_press_seen), 32'd1);
        btn = 1'b0;
        c0  = cyc;
        ticks(20);
        check("release_latency", 32'(hold_fall_cyc - c0), 32'd11);
        check("no_repeat_short", 32'(n_rep_seen), 32'd0);

        // Bounce every 3 cycles is rejected.
        do_reset(2);
        clear_meas();
        for (int i = 0; i < 30; i++) begin
            btn = ((i / 3) % 2 == 0);
            tick();
        end
        btn = 1'b0;
        ticks(15);
        check("bounce_no_press", 32'(n_press_seen), 32'd0);
        check("bounce_count", 32'(press_count), 32'd0);

        // Long hold: repeat cadence.
        do_reset(2);
        clear_meas();
        btn = 1'b1;
        ticks(200);
        btn = 1'b0;
        ticks(20);
        check("repeat_first_delay", 32'(first_rep_cyc - last_press_cyc), 32'(DLY));
        check("repeat_total", 32'(n_rep_seen), 32'(m_nrep));
        check("repeat_one_press", 32'(n_press_seen), 32'd1);

        // Release bounce while held: no release, cadence shifted by frozen edges.
        do_reset(2);
        clear_meas();
        btn = 1'b1;
        ticks(30);
        btn = 1'b0;
        ticks(4);
        btn = 1'b1;
        ticks(150);
        check("rb_no_fall", 32'(n_fall_seen), 32'd0);
        check("rb_one_press", 32'(n_press_seen), 32'd1);
        check("rb_first_repeat", 32'(first_rep_cyc - last_press_cyc), 32'(DLY + 5));
        btn = 1'b0;
        ticks(15);

        // 256 clean presses wrap the counter, the next gives 1.
        do_reset(2);
        clear_meas();
        for (int i = 0; i < 256; i++) begin
            btn = 1'b1;
            ticks(12);
            btn = 1'b0;
            ticks(12);
        end
        check("wrap_zero", 32'(press_count), 32'd0);
        check("wrap_presses", 32'(n_press_seen), 32'd256);
        btn = 1'b1;
        ticks(12);
        btn = 1'b0;
        ticks(12);
        check("wrap_one", 32'(press_count), 32'd1);

        // Reset during DB_PRESS then during HELD; btn kept high throughout.
        do_reset(2);
        clear_meas();
        btn = 1'b1;
        ticks(7);
        do_reset(1);
        check("rst_db_no_press", 32'(n_press_seen), 32'd0);
        c0 = cyc;
        ticks(31);
        check("rst_db_relatency", 32'(last_press_cyc - c0), 32'd11);
        do_reset(1);
        check("rst_held_hold", 32'(hold), 32'd0);
        check("rst_held_count", 32'(press_count), 32'd0);
        c0 = cyc;
        ticks(15);
        check("rst_held_relatency", 32'(last_press_cyc - c0), 32'd11);

        // Random button runs with occasional resets.
        btn = 1'b0;
        for (int i = 0; i < 400; i++) begin
            btn     = $urandom_range(0, 1);
            run_len = (($urandom_range(0, 3) == 0) ? $urandom_range(9, 90) : $urandom_range(1, 12));
            for (int k = 0; k < run_len; k++) begin
                rst = ($urandom_range(0, 299) == 0);
                tick();
            end
            rst = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
